// File: rtl/dbg_rom_loader_if.sv
// Debug bus bundle: address/write strobe/write data out, read data back.
// The master drives the access, the slave returns registered read data.
interface dbg_rom_loader_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [AW-1:0] addr;
  logic          wen;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (
    output addr, wen, wdata,
    input  rdata
  );

  modport slave (
    input  addr, wen, wdata,
    output rdata
  );
endinterface

// File: rtl/dbg_rom_loader.sv
// Debug-bus sequencer: holds the system in reset, streams a ROM image in,
// releases reset and confirms the release; host pass-through when idle.
module dbg_rom_loader #(
  parameter int         ROM_BYTES       = 4096,
  parameter int         RST_HOLD        = 4,
  parameter int         TIMEOUT         = 1024,
  parameter logic [7:0] CTL_RST_ASSERT  = 8'hFF,
  parameter logic [7:0] CTL_RST_RELEASE = 8'h00,
  localparam int        LEN_W = $clog2(ROM_BYTES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  dbg_rom_loader_if.slave  h,
  dbg_rom_loader_if.master dbg
);
  localparam int OFF_W  = 12;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [3:0] SEG_CTL = 4'h0;
  localparam logic [3:0] SEG_ROM = 4'h1;
  localparam logic [OFF_W-1:0] CTL_PC_LO = 12'h000;
  localparam logic [OFF_W-1:0] CTL_SYS_RST = 12'h010;

  localparam logic [15:0] PARK = {SEG_CTL, CTL_PC_LO};
  localparam logic [15:0] RST_ADDR = {SEG_CTL, CTL_SYS_RST};

  typedef enum logic [3:0] {
    IDLE, RST_ON, HOLD, LOAD, RST_OFF,
    RB0, RB1, CHECK, FAIL
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [OFF_W-1:0]  idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              len_ok;
  logic              last;

  assign len_ok = (load_len != '0) &&
                  (load_len <= LEN_W'(ROM_BYTES));
  assign last   = LEN_W'(idx) == len - LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      len      <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          done <= 1'b0;
          if (len_ok) begin
            len   <= load_len;
            err   <= 1'b0;
            state <= RST_ON;
          end else begin
            err <= 1'b1;
          end
        end
        RST_ON: begin
          hold_cnt <= HOLD_W'(RST_HOLD);
          state    <= HOLD;
        end
        HOLD: begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) begin
            idx    <= '0;
            to_cnt <= '0;
            state  <= LOAD;
          end
        end
        LOAD: if (s_valid) begin
          idx    <= idx + OFF_W'(1);
          to_cnt <= '0;
          if (last) state <= RST_OFF;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
          // Resets stay asserted on abort.
          if (to_cnt == TO_W'(TIMEOUT - 1))
            state <= FAIL;
        end
        RST_OFF: state <= RB0;
        RB0:     state <= RB1;
        RB1:     state <= CHECK;
        CHECK: if (dbg.rdata == CTL_RST_RELEASE) begin
          done  <= 1'b1;
          state <= IDLE;
        end else begin
          state <= FAIL;
        end
        FAIL: begin
          err   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = state != IDLE;
  assign s_ready = state == LOAD;
  assign h.rdata = dbg.rdata;

  logic [15:0] addr;
  logic        wen;
  logic [7:0]  wdata;

  // ROM is decoded from segment alone: only beat cycles carry SEG_ROM.
  always_comb begin
    addr  = PARK;
    wen   = 1'b0;
    wdata = 8'h00;
    unique case (state)
      IDLE: begin
        addr  = h.addr;
        wen   = h.wen;
        wdata = h.wdata;
      end
      RST_ON: begin
        addr  = RST_ADDR;
        wen   = 1'b1;
        wdata = CTL_RST_ASSERT;
      end
      LOAD: if (s_valid) begin
        addr  = {SEG_ROM, idx};
        wen   = 1'b1;
        wdata = s_data;
      end
      RST_OFF: begin
        addr  = RST_ADDR;
        wen   = 1'b1;
        wdata = CTL_RST_RELEASE;
      end
      RB0, RB1, CHECK: addr = RST_ADDR;
      default: ;
    endcase
  end

  assign dbg.addr  = addr;
  assign dbg.wen   = wen;
  assign dbg.wdata = wdata;
endmodule
